// File: rtl/mem_arb_pkg.sv
// Shared types for the memory channel arbiter.
//   arb_state_e : FSM encoding (IDLE / ISSUE / WAIT), 2 bits.
//   arb_cmd_t   : latched command fields (index, write, burst, mask, data).
// The struct fields are sized by CMD_IDX_W / CMD_DATA_W; the arbiter's
// IDX_W / DATA_W parameters must not exceed these.
package mem_arb_pkg;

  localparam int CMD_IDX_W  = 19;
  localparam int CMD_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [CMD_IDX_W-1:0]  index;
    logic                  write;
    logic                  burst;
    logic [CMD_DATA_W-1:0] mask;
    logic [CMD_DATA_W-1:0] data;
  } arb_cmd_t;

endpackage

// File: rtl/mem_arb_picker.sv
// Combinational winner selection for the memory channel arbiter.
//   valid     : per-channel request valid
//   ptr       : round-robin start channel (ignored when ROUND_ROBIN = 0)
//   winner_oh : one-hot winner, all zero when nothing is valid
// ROUND_ROBIN = 0 : lowest channel index wins.
// ROUND_ROBIN = 1 : search starts at ptr and wraps modulo NUM_CH.
module mem_arb_picker #(
  parameter int NUM_CH      = 3,
  parameter int PTR_W       = 2,
  parameter bit ROUND_ROBIN = 1'b0
) (
  input  logic [NUM_CH-1:0] valid,
  input  logic [PTR_W-1:0]  ptr,
  output logic [NUM_CH-1:0] winner_oh
);

  always_comb begin
    int   start;
    int   idx;
    logic found;
    winner_oh = '0;
    found     = 1'b0;
    idx       = 0;
    start     = ROUND_ROBIN ? int'(ptr) : 0;
    if (start >= NUM_CH) start = 0;
    for (int k = 0; k < NUM_CH; k++) begin
      idx = start + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      // Constant inner index keeps the selects fixed-width.
      for (int j = 0; j < NUM_CH; j++) begin
        if (j == idx && !found && valid[j]) begin
          winner_oh[j] = 1'b1;
          found        = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_channel_arb.sv
// N-channel arbiter in front of a single-ported DDR model. One transaction
// is outstanding at a time: accept in IDLE, strobe the command in ISSUE,
// wait for ddr_operation_done in WAIT, then pulse rsp_done to the granted
// channel one cycle later.
//
// Handshake: a requester holds req_valid and its fields stable until its
// req_ready bit pulses (combinationally, in IDLE); the fields are latched at
// that clock edge and valid may drop the cycle after. Dropping valid before
// being granted is allowed.
//
// Ports:
//   clock, reset_n            clock, asynchronous active-low reset
//   req_valid/ready/write/burst, req_index/wmask/wdata (flattened, channel i
//                              at [i*W +: W])      requester side
//   rsp_done, rsp_rdata, rsp_burst_data          completion side
//   ddr_*                     DDR command/response side
//   dbg_state                 current FSM state (arb_state_e encoding)
//
// Build option: define MEM_ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise fixed priority (channel 0 highest) with no pointer register.
module mem_channel_arb
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int IDX_W   = CMD_IDX_W,
  parameter int DATA_W  = CMD_DATA_W,
  parameter int BURST_W = 512
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NUM_CH-1:0]        req_valid,
  output logic [NUM_CH-1:0]        req_ready,
  input  logic [NUM_CH-1:0]        req_write,
  input  logic [NUM_CH-1:0]        req_burst,
  input  logic [NUM_CH*IDX_W-1:0]  req_index,
  input  logic [NUM_CH*DATA_W-1:0] req_wmask,
  input  logic [NUM_CH*DATA_W-1:0] req_wdata,
  output logic [NUM_CH-1:0]        rsp_done,
  output logic [DATA_W-1:0]        rsp_rdata,
  output logic [BURST_W-1:0]       rsp_burst_data,
  output logic                     ddr_chip_enable,
  output logic [IDX_W-1:0]         ddr_index,
  output logic                     ddr_write_enable,
  output logic                     ddr_burst_mode,
  output logic [DATA_W-1:0]        ddr_write_mask,
  output logic [DATA_W-1:0]        ddr_write_data,
  input  logic [DATA_W-1:0]        ddr_read_data,
  input  logic [BURST_W-1:0]       ddr_burst_read_data,
  input  logic                     ddr_operation_done,
  input  logic                     ddr_ready,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  arb_state_e          state_q, state_d;
  arb_cmd_t            cmd_q, cmd_sel;
  logic [NUM_CH-1:0]   grant_q, win_oh, rsp_done_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic [BURST_W-1:0]  rsp_burst_q;
  logic [PTR_W-1:0]    ptr;
  logic                accept;
  logic                done_seen;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
  logic [PTR_W-1:0] ptr_q, ptr_nxt;

  // Pointer moves to the channel after the winner, wrapping to 0.
  always_comb begin
    ptr_nxt = ptr_q;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_oh[i]) ptr_nxt = (i == NUM_CH - 1) ? '0 : PTR_W'(i + 1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)    ptr_q <= '0;
    else if (accept) ptr_q <= ptr_nxt;
  end

  assign ptr = ptr_q;
`else
  localparam bit RR_EN = 1'b0;
  assign ptr = '0;
`endif

  mem_arb_picker #(
    .NUM_CH      (NUM_CH),
    .PTR_W       (PTR_W),
    .ROUND_ROBIN (RR_EN)
  ) u_picker (
    .valid     (req_valid),
    .ptr       (ptr),
    .winner_oh (win_oh)
  );

  // No accept in the rsp_done cycle: a request seen then is taken the
  // following cycle, which sets the 4-cycle accept spacing. reset_n gates
  // the combinational ready so nothing is accepted while reset is held.
  assign accept = reset_n && (state_q == IDLE) && ddr_ready &&
                  (|req_valid) && !(|rsp_done_q);
  assign req_ready = accept ? win_oh : '0;
  assign done_seen = (state_q == WAIT) && ddr_operation_done;

  // Mux the winning channel's fields into a command record.
  always_comb begin
    cmd_sel = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_oh[i]) begin
        cmd_sel.index[IDX_W-1:0] = req_index[i*IDX_W +: IDX_W];
        cmd_sel.write            = req_write[i];
        cmd_sel.burst            = req_burst[i];
        cmd_sel.mask[DATA_W-1:0] = req_wmask[i*DATA_W +: DATA_W];
        cmd_sel.data[DATA_W-1:0] = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (ddr_operation_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      cmd_q       <= '0;
      rsp_done_q  <= '0;
      rsp_rdata_q <= '0;
      rsp_burst_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_done_q <= '0;
      if (accept) begin
        grant_q <= win_oh;
        cmd_q   <= cmd_sel;
      end
      if (done_seen) begin
        rsp_done_q <= grant_q;
        if (!cmd_q.write) begin
          if (cmd_q.burst) rsp_burst_q <= ddr_burst_read_data;
          else             rsp_rdata_q <= ddr_read_data;
        end
      end
    end
  end

  assign rsp_done         = rsp_done_q;
  assign rsp_rdata        = rsp_rdata_q;
  assign rsp_burst_data   = rsp_burst_q;
  assign ddr_chip_enable  = (state_q == ISSUE);
  assign ddr_index        = cmd_q.index[IDX_W-1:0];
  assign ddr_write_enable = cmd_q.write;
  assign ddr_burst_mode   = cmd_q.burst & ~cmd_q.write;
  assign ddr_write_mask   = cmd_q.mask[DATA_W-1:0];
  assign ddr_write_data   = cmd_q.data[DATA_W-1:0];
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_mem_channel_arb.sv
// Directed bench for mem_channel_arb: reset / reset-in-WAIT, backpressure,
// a table of single transactions, fixed contention and (when built with
// MEM_ARB_ROUND_ROBIN_EN) round-robin contention.
module tb_mem_channel_arb;

  localparam int NUM_CH  = 3;
  localparam int IDX_W   = 19;
  localparam int DATA_W  = 64;
  localparam int BURST_W = 512;

  logic                     clock;
  logic                     reset_n;
  logic [NUM_CH-1:0]        req_valid, req_ready, req_write, req_burst;
  logic [NUM_CH*IDX_W-1:0]  req_index;
  logic [NUM_CH*DATA_W-1:0] req_wmask, req_wdata;
  logic [NUM_CH-1:0]        rsp_done;
  logic [DATA_W-1:0]        rsp_rdata;
  logic [BURST_W-1:0]       rsp_burst_data;
  logic                     ddr_chip_enable, ddr_write_enable, ddr_burst_mode;
  logic [IDX_W-1:0]         ddr_index;
  logic [DATA_W-1:0]        ddr_write_mask, ddr_write_data, ddr_read_data;
  logic [BURST_W-1:0]       ddr_burst_read_data;
  logic                     ddr_operation_done, ddr_ready;
  logic [1:0]               dbg_state;

  mem_channel_arb #(
    .NUM_CH(NUM_CH), .IDX_W(IDX_W), .DATA_W(DATA_W), .BURST_W(BURST_W)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_burst(req_burst),
    .req_index(req_index), .req_wmask(req_wmask), .req_wdata(req_wdata),
    .rsp_done(rsp_done), .rsp_rdata(rsp_rdata), .rsp_burst_data(rsp_burst_data),
    .ddr_chip_enable(ddr_chip_enable), .ddr_index(ddr_index),
    .ddr_write_enable(ddr_write_enable), .ddr_burst_mode(ddr_burst_mode),
    .ddr_write_mask(ddr_write_mask), .ddr_write_data(ddr_write_data),
    .ddr_read_data(ddr_read_data), .ddr_burst_read_data(ddr_burst_read_data),
    .ddr_operation_done(ddr_operation_done), .ddr_ready(ddr_ready),
    .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          ch;
    logic        wr;
    logic        bu;
    logic [18:0] idx;
    logic [63:0] mask;
    logic [63:0] wdata;
    logic [63:0] rd;     // ddr_read_data at done
    logic [63:0] bd;     // burst data pattern, replicated 8x at done
    int          delay;  // WAIT cycles before done
    bit          early;  // also pulse done in IDLE and ISSUE (must be ignored)
    logic [2:0]  exp_ready;
    logic        exp_we;
    logic        exp_bm;
  } vec_t;

  vec_t              vecs[6];
  vec_t              bp_vec;
  logic [63:0]       model_rdata;
  logic [511:0]      model_burst;
  logic [NUM_CH-1:0] exp_q[$];

  // Driver: one complete transaction on a single channel.
  task automatic do_txn(input vec_t v);
    bit got;
    if (v.early) begin
      @(posedge clock); #1;
      ddr_operation_done = 1'b1;
      ddr_read_data      = 64'h9999_9999_9999_9999;
      @(negedge clock);
      check("idle_done_no_rsp", rsp_done, 3'b000);
      @(posedge clock); #1;
      ddr_operation_done = 1'b0;
      @(negedge clock);
      check("idle_done_state", dbg_state, 2'd0);
    end
    @(posedge clock); #1;
    req_write[v.ch] = v.wr;
    req_burst[v.ch] = v.bu;
    req_index[v.ch*IDX_W +: IDX_W]   = v.idx;
    req_wmask[v.ch*DATA_W +: DATA_W] = v.mask;
    req_wdata[v.ch*DATA_W +: DATA_W] = v.wdata;
    req_valid[v.ch] = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clock);
      if (req_ready != '0) got = 1;
    end
    check("req_ready", got ? req_ready : 3'b000, v.exp_ready);
    @(posedge clock); #1;
    req_valid[v.ch] = 1'b0;
    @(negedge clock);  // ISSUE
    check("ce_issue", ddr_chip_enable, 1'b1);
    check("ddr_index", ddr_index, v.idx);
    check("ddr_write_enable", ddr_write_enable, v.exp_we);
    check("ddr_burst_mode", ddr_burst_mode, v.exp_bm);
    check("ddr_write_mask", ddr_write_mask, v.mask);
    check("ddr_write_data", ddr_write_data, v.wdata);
    if (v.early) begin
      ddr_operation_done = 1'b1;
      ddr_read_data      = 64'h9999_9999_9999_9999;
      ddr_burst_read_data = {8{64'h7777_7777_7777_7777}};
    end
    @(posedge clock); #1;
    @(negedge clock);  // WAIT cycle 0
    ddr_operation_done = 1'b0;
    check("ce_wait", ddr_chip_enable, 1'b0);
    check("state_wait", dbg_state, 2'd2);
    check("no_early_rsp", rsp_done, 3'b000);
    repeat (v.delay) @(negedge clock);
    ddr_operation_done  = 1'b1;
    ddr_read_data       = v.rd;
    ddr_burst_read_data = {8{v.bd}};
    @(posedge clock); #1;
    ddr_operation_done  = 1'b0;
    ddr_read_data       = ~v.rd;
    ddr_burst_read_data = ~{8{v.bd}};
    if (!v.wr && !v.bu) model_rdata = v.rd;
    if (!v.wr && v.bu)  model_burst = {8{v.bd}};
    @(negedge clock);
    check("rsp_done", rsp_done, v.exp_ready);
    check("rsp_rdata", rsp_rdata, model_rdata);
    check("rsp_burst_data", rsp_burst_data, model_burst);
    @(negedge clock);
    check("rsp_done_clear", rsp_done, 3'b000);
  endtask

  // Multi-channel contention; DDR answers done in the first WAIT cycle.
  // hold = 1 keeps the valids up until n grants are seen.
  task automatic run_contention(input logic [2:0] valids, input bit hold,
                                input int n);
    logic [2:0] prev_ready, last_grant, r, rd;
    logic       ce, done_now;
    int         last_acc, n_grant, n_rsp;
    prev_ready = '0; last_grant = '0; done_now = 1'b0;
    last_acc = -1; n_grant = 0; n_rsp = 0;
    @(posedge clock); #1;
    req_valid = valids;
    for (int c = 0; c < 80 && n_rsp < n; c++) begin
      @(negedge clock);
      r = req_ready; ce = ddr_chip_enable; rd = rsp_done;
      if (r != '0) begin
        if (exp_q.size() == 0) check("extra_grant", r, 3'b000);
        else check("grant_order", r, exp_q.pop_front());
        // accept, ISSUE, WAIT+done, rsp_done cycle, then next accept
        if (last_acc >= 0) check("accept_gap", c - last_acc, 4);
        last_acc = c; last_grant = r; n_grant++;
      end
      if (rd != '0) begin
        check("rsp_route", rd, last_grant);
        n_rsp++;
      end
      if (!hold) req_valid = req_valid & ~prev_ready;
      else if (n_grant >= n && prev_ready != '0) req_valid = '0;
      ddr_operation_done = done_now;
      ddr_read_data      = 64'h0000_0000_0000_1000 + 64'(c);
      done_now = ce;
      prev_ready = r;
    end
    check("contention_rsp_count", n_rsp, n);
    check("contention_queue_empty", exp_q.size(), 0);
    ddr_operation_done = 1'b0;
    req_valid = '0;
    @(negedge clock);
  endtask

  initial begin
    vecs[0] = '{1, 1'b0, 1'b0, 19'h12345, 64'h0, 64'h0,
                64'hDEAD_BEEF_0000_0001, 64'h5555_0000_5555_0000, 2, 1'b0,
                3'b010, 1'b0, 1'b0};
    vecs[1] = '{2, 1'b0, 1'b1, 19'h00040, 64'h0, 64'h0,
                64'h1111_1111_1111_1111, 64'h0123_4567_89AB_CDEF, 1, 1'b0,
                3'b100, 1'b0, 1'b1};
    vecs[2] = '{0, 1'b1, 1'b1, 19'h7FFFF, 64'hFF00_FF00_FF00_FF00,
                64'h0123_4567_89AB_CDEF, 64'h2222_2222_2222_2222,
                64'h3333_3333_3333_3333, 0, 1'b0, 3'b001, 1'b1, 1'b0};
    vecs[3] = '{1, 1'b0, 1'b0, 19'h00000, 64'hFFFF_0000_0000_FFFF,
                64'hAAAA_BBBB_CCCC_DDDD, 64'hCAFE_F00D_1234_5678,
                64'h4444_4444_4444_4444, 4, 1'b1, 3'b010, 1'b0, 1'b0};
    vecs[4] = '{0, 1'b0, 1'b1, 19'h3FFFF, 64'h0, 64'h0,
                64'h6666_6666_6666_6666, 64'hFEDC_BA98_7654_3210, 2, 1'b0,
                3'b001, 1'b0, 1'b1};
    vecs[5] = '{2, 1'b0, 1'b0, 19'h55555, 64'h0, 64'h0,
                64'hA5A5_A5A5_5A5A_5A5A, 64'h8888_8888_8888_8888, 0, 1'b0,
                3'b100, 1'b0, 1'b0};
    bp_vec  = '{0, 1'b0, 1'b0, 19'h00ABC, 64'h0, 64'h0,
                64'h0F0F_0F0F_0F0F_0F0F, 64'h0, 1, 1'b0,
                3'b001, 1'b0, 1'b0};
    model_rdata = '0;
    model_burst = '0;

    // Reset with all valids high: everything stays 0.
    reset_n = 1'b0; req_valid = 3'b111; ddr_ready = 1'b1;
    req_write = '0; req_burst = '0; req_index = '0;
    req_wmask = '0; req_wdata = '0;
    ddr_read_data = '0; ddr_burst_read_data = '0; ddr_operation_done = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_req_ready", req_ready, 3'b000);
    check("rst_rsp_done", rsp_done, 3'b000);
    check("rst_ddr_cmd", {ddr_chip_enable, ddr_write_enable, ddr_burst_mode,
                          ddr_index, ddr_write_mask, ddr_write_data}, '0);
    check("rst_rsp_data", {rsp_rdata, rsp_burst_data}, '0);
    check("rst_state", dbg_state, 2'd0);

    // Release: first accept happens at the edge after release; then reset
    // again in WAIT while done is high -> no rsp_done.
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rel_state_idle", dbg_state, 2'd0);
    check("rel_req_ready", req_ready, 3'b001);
    @(posedge clock); #1;
    req_valid = '0;
    @(negedge clock);
    check("rel_ce", ddr_chip_enable, 1'b1);
    @(posedge clock); #1;
    @(negedge clock);
    check("rel_state_wait", dbg_state, 2'd2);
    ddr_operation_done = 1'b1;
    ddr_read_data      = 64'hBAD0_BAD0_BAD0_BAD0;
    reset_n = 1'b0;
    #1;
    check("midrst_state", dbg_state, 2'd0);
    check("midrst_rsp_done", rsp_done, 3'b000);
    @(posedge clock); #1;
    ddr_operation_done = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("postrst_rsp_done", rsp_done, 3'b000);
      check("postrst_state", dbg_state, 2'd0);
      check("postrst_rdata", rsp_rdata, 64'h0);
    end

    // Backpressure: ddr_ready low blocks acceptance.
    @(posedge clock); #1;
    ddr_ready = 1'b0;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("bp_req_ready", req_ready, 3'b000);
      check("bp_state", dbg_state, 2'd0);
    end
    @(posedge clock); #1;
    req_valid[0] = 1'b0;
    ddr_ready = 1'b1;
    do_txn(bp_vec);

    // Table of single transactions.
    for (int i = 0; i < 6; i++) do_txn(vecs[i]);

    // All three channels contending; ends with pointer at 0 in RR builds too.
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b010);
    exp_q.push_back(3'b100);
    run_contention(3'b111, 1'b0, 3);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b001);
    exp_q.push_back(3'b100);
    run_contention(3'b101, 1'b1, 4);
`endif

    repeat (2) @(negedge clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
